// File: rtl/bsg_link_core_wide_to_narrow_if.sv
// Handshake bundle between the wide core side and the narrow link side.
// The slave modport is the feeder itself; master is whatever drives it.
interface bsg_link_core_wide_to_narrow_if #(
  parameter int width_out_p   = 64,
  parameter int ratio_p       = 2,
  parameter int count_width_p = 32
);
  logic [width_out_p*ratio_p-1:0] data_i;
  logic                           valid_i;
  logic                           ready_o;
  logic [width_out_p-1:0]         data_o;
  logic                           valid_o;
  logic                           ready_i;
  logic                           last_o;
  logic [count_width_p-1:0]       sent_count_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o,
    output last_o, sent_count_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o,
    input  last_o, sent_count_o
  );
endinterface

// File: rtl/bsg_link_core_wide_to_narrow.sv
// Buffers wide core messages and emits them as ratio_p narrow beats,
// low slice first, with a free-running count of beats sent.
module bsg_link_core_wide_to_narrow #(
  parameter int width_out_p   = 64,
  parameter int ratio_p       = 2,
  parameter int els_p         = 2,
  parameter int count_width_p = 32
) (
  input logic core_clk_i,
  input logic core_link_reset_i,
  bsg_link_core_wide_to_narrow_if.slave link
);
  localparam int WI = width_out_p * ratio_p;
  localparam int AW = $clog2(els_p);
  localparam int BW = $clog2(ratio_p);

  logic [WI-1:0] mem_q [els_p];
  logic [WI-1:0] mem_d [els_p];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic ready_q, ready_d;
  logic [count_width_p-1:0] cnt_q, cnt_d;

  logic empty, enq, xfer, last_beat;
  logic [ratio_p-1:0][width_out_p-1:0] head;

  assign empty     = (wptr_q == rptr_q);
  assign enq       = link.valid_i & ready_q;
  assign xfer      = ~empty & link.ready_i;
  assign last_beat = (beat_q == BW'(ratio_p-1));
  assign head      = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (enq) begin
      mem_d[wptr_q[AW-1:0]] = link.data_i;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (xfer) begin
      cnt_d = cnt_q + count_width_p'(1);
      if (last_beat) begin
        beat_d = '0;
        rptr_d = rptr_q + (AW+1)'(1);
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
    // ready is registered from next-state fullness, so no same-cycle bypass
    ready_d = ~((wptr_d[AW] != rptr_d[AW]) &&
                (wptr_d[AW-1:0] == rptr_d[AW-1:0]));
  end

  always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
    if (core_link_reset_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      beat_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      beat_q  <= beat_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign link.ready_o      = ready_q;
  assign link.valid_o      = ~empty;
  assign link.data_o       = empty ? '0 : head[beat_q];
  assign link.last_o       = ~empty & last_beat;
  assign link.sent_count_o = cnt_q;
endmodule

// File: tb/tb_bsg_link_core_wide_to_narrow.sv
// Directed plus random stimulus for the wide-to-narrow feeder,
// checked every cycle against a beat-queue reference model.
module tb_bsg_link_core_wide_to_narrow;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bsg_link_core_wide_to_narrow_if #(
    .width_out_p(64), .ratio_p(2), .count_width_p(4)
  ) bus ();

  bsg_link_core_wide_to_narrow #(
    .width_out_p(64), .ratio_p(2),
    .els_p(2), .count_width_p(4)
  ) dut (
    .core_clk_i(clk),
    .core_link_reset_i(rst),
    .link(bus.slave)
  );

  typedef struct { logic [63:0] d; bit l; } beat_t;
  beat_t mq[$];
  bit m_ready;
  logic [3:0] m_cnt;
  bit last_enq;
  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_msg(logic [127:0] m);
    for (int r = 0; r < 2; r++) begin
      beat_t b;
      b.d = m[r*64 +: 64];
      b.l = (r == 1);
      mq.push_back(b);
    end
  endtask

  function automatic int occ();
    return (mq.size() + 1) / 2;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cnt = '0;
    m_ready = 1'b0;
    last_enq = 1'b0;
  endtask

  task automatic cycle();
    bit enq, deq;
    logic [127:0] din;
    @(negedge clk);
    chk("ready_o", bus.ready_o, m_ready);
    chk("valid_o", bus.valid_o, mq.size() > 0);
    chk("data_o", bus.data_o, mq.size() ? mq[0].d : 64'h0);
    chk("last_o", bus.last_o, mq.size() ? mq[0].l : 1'b0);
    chk("count", bus.sent_count_o, m_cnt);
    din = bus.data_i;
    enq = bus.valid_i && m_ready && !rst;
    deq = (mq.size() > 0) && bus.ready_i && !rst;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (deq) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (enq) push_msg(din);
      m_ready = (occ() < 2);
      last_enq = enq;
    end
    #1;
  endtask

  task automatic drain();
    int k = 0;
    bus.ready_i = 1'b1;
    while (mq.size() > 0 && k < 50) begin
      cycle();
      k++;
    end
    chk("drain_timeout", mq.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    bit seen;
    logic [3:0] prev;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.data_i = '0;
    model_clear();
    #2;
    chk("rst_ready", bus.ready_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_last", bus.last_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_count", bus.sent_count_o, 0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", bus.ready_o, 1);

    // single message
    bus.data_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    cycle();
    bus.valid_i = 1'b0;
    chk("t1_b0", bus.data_o, 64'h5555_6666_7777_8888);
    chk("t1_b0_last", bus.last_o, 0);
    cycle();
    chk("t1_b1", bus.data_o, 64'h1111_2222_3333_4444);
    chk("t1_b1_last", bus.last_o, 1);
    cycle();
    chk("t1_done_valid", bus.valid_o, 0);
    chk("t1_done_count", bus.sent_count_o, 2);

    // backpressure until full
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i = rnd();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (last_enq) begin
        n_acc++;
        bus.data_i = rnd();
      end
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_full_ready", bus.ready_o, 0);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 10 && !last_enq; i++) cycle();
    chk("bp_third_taken", last_enq, 1);
    bus.valid_i = 1'b0;
    drain();

    // stall mid-message
    bus.data_i = rnd();
    bus.valid_i = 1'b1;
    cycle();
    bus.valid_i = 1'b0;
    cycle();
    bus.ready_i = 1'b0;
    repeat (5) begin
      cycle();
      chk("stall_last", bus.last_o, 1);
    end
    drain();

    // streaming
    bus.data_i = 128'd1;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    n_acc = 0;
    repeat (100) begin
      cycle();
      if (last_enq) begin
        n_acc++;
        bus.data_i = bus.data_i + 128'd1;
      end
    end
    chk("stream_rate", n_acc, 51);
    bus.valid_i = 1'b0;
    drain();

    // random traffic
    bus.data_i = rnd();
    repeat (200) begin
      bus.valid_i = 1'($urandom_range(0, 1));
      bus.ready_i = 1'($urandom_range(0, 1));
      cycle();
      if (last_enq) bus.data_i = rnd();
    end
    bus.valid_i = 1'b0;
    drain();

    // async reset mid-message
    bus.data_i = rnd();
    bus.valid_i = 1'b1;
    cycle();
    bus.valid_i = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", bus.ready_o, 0);
    chk("arst_valid", bus.valid_o, 0);
    chk("arst_data", bus.data_o, 0);
    chk("arst_last", bus.last_o, 0);
    chk("arst_count", bus.sent_count_o, 0);
    model_clear();
    repeat (2) cycle();
    rst = 1'b0;
    bus.data_i = 128'hAAAA_BBBB_CCCC_DDDD_0123_4567_89AB_CDEF;
    bus.valid_i = 1'b1;
    for (int i = 0; i < 4 && !last_enq; i++) cycle();
    bus.valid_i = 1'b0;
    chk("arst_new_b0", bus.data_o, 64'h0123_4567_89AB_CDEF);
    chk("arst_new_cnt", bus.sent_count_o, 0);
    drain();
    chk("arst_end_cnt", bus.sent_count_o, 2);

    // counter wrap
    rst = 1'b1;
    #1 model_clear();
    cycle();
    rst = 1'b0;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i = rnd();
    n_acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 80 && (n_acc < 9 || mq.size() > 0); i++) begin
      prev = bus.sent_count_o;
      cycle();
      if (last_enq) begin
        n_acc++;
        bus.data_i = rnd();
        if (n_acc == 9) bus.valid_i = 1'b0;
      end
      if (prev == 4'd15 && bus.sent_count_o == 4'd0) seen = 1'b1;
    end
    chk("wrap_msgs", n_acc, 9);
    chk("wrap_seen", seen, 1);
    chk("wrap_end", bus.sent_count_o, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end
endmodule
